// File: rtl/shift_arbiter_8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_arbiter_8_pkg
// Description : Shared widths and state encoding for the shift arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_arbiter_8_pkg;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int SHAMT_W = 3;
    localparam int ID_W    = 2;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_arbiter_8_shifter.sv
`default_nettype none
// ============================================================================
// Module      : shift_arbiter_8_shifter
// Description : 8-bit zero-filling left shifter shared by all requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_arbiter_8_shifter
    import shift_arbiter_8_pkg::*;
(
    input  logic [DATA_W-1:0]  i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    output logic [DATA_W-1:0]  o_data
);

    assign o_data = i_data << i_shamt;

endmodule
`default_nettype wire

// File: rtl/shift_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module      : shift_arbiter_8
// Description : Round-robin arbiter feeding one shared left shifter into a
//               single-entry result register.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_arbiter_8
    import shift_arbiter_8_pkg::*;
(
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [NUM_REQ-1:0]           i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    i_req_data,
    input  logic [NUM_REQ*SHAMT_W-1:0]   i_req_shamt,
    output logic [NUM_REQ-1:0]           o_req_ready,
    output logic                         o_rsp_valid,
    output logic [DATA_W-1:0]            o_rsp_data,
    output logic [ID_W-1:0]              o_rsp_id,
    input  logic                         i_rsp_ready
);

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;

    logic [NUM_REQ-1:0]  w_rot;
    logic                w_any;
    logic [ID_W-1:0]     w_off;
    logic [ID_W-1:0]     w_winner;
    logic                w_can_accept;
    logic                w_xfer;
    logic                w_drain;
    logic [DATA_W-1:0]   w_operand;
    logic [SHAMT_W-1:0]  w_shamt;
    logic [DATA_W-1:0]   w_shifted;

    // Rotate so that bit 0 is the requester at ptr; the lowest set bit wins.
    always_comb begin
        w_rot = NUM_REQ'({i_req_valid, i_req_valid} >> ptr_q);
        w_any = |w_rot;
        w_off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = ID_W'(i);
            end
        end
        w_winner = ptr_q + w_off;
    end

    assign w_can_accept = i_rst_n && ((state_q == EMPTY) || i_rsp_ready);
    assign o_req_ready  = (w_any && w_can_accept) ? (NUM_REQ'(1) << w_winner) : '0;
    assign w_xfer       = |(i_req_valid & o_req_ready);
    assign w_drain      = (state_q == FULL) && i_rsp_ready;

    assign w_operand = i_req_data[w_winner*DATA_W +: DATA_W];
    assign w_shamt   = i_req_shamt[w_winner*SHAMT_W +: SHAMT_W];

    shift_arbiter_8_shifter u_shifter (
        .i_data  (w_operand),
        .i_shamt (w_shamt),
        .o_data  (w_shifted)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        case (state_q)
            EMPTY:   if (w_xfer)              state_d = FULL;
            FULL:    if (w_drain && !w_xfer)  state_d = EMPTY;
            default:                          state_d = EMPTY;
        endcase
        if (w_xfer) begin
            rsp_data_d = w_shifted;
            rsp_id_d   = w_winner;
            ptr_d      = w_winner + ID_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= EMPTY;
            ptr_q      <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign o_rsp_valid = (state_q == FULL);
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_id    = rsp_id_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_arbiter_8
// Description : Directed self-checking bench for shift_arbiter_8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_arbiter_8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [11:0] req_shamt;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        rsp_ready;

    int n_tests = 0;
    int n_fail  = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    shift_arbiter_8 dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .i_req_shamt (req_shamt),
        .o_req_ready (req_ready),
        .o_rsp_valid (rsp_valid),
        .o_rsp_data  (rsp_data),
        .o_rsp_id    (rsp_id),
        .i_rsp_ready (rsp_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [7:0] d, input logic [2:0] s);
        req_data[k*8 +: 8]  = d;
        req_shamt[k*3 +: 3] = s;
    endtask

    // Continuous monitors: one-hot grant, grant only to requesters, stable output under stall.
    logic       stall_prev = 1'b0;
    logic [7:0] hold_data;
    logic [1:0] hold_id;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
            chk("ready_subset", 32'((req_ready & ~req_valid) == 4'd0), 32'd1);
            if (stall_prev) begin
                chk("stall_data", 32'(rsp_data), 32'(hold_data));
                chk("stall_id",   32'(rsp_id),   32'(hold_id));
            end
            stall_prev = rsp_valid && !rsp_ready && rst_n;
            hold_data  = rsp_data;
            hold_id    = rsp_id;
        end
    end

    logic [7:0] sweep_exp [8];
    int         mptr;
    int         wexp;
    int         wobs;
    int         wait0;
    int         max_wait0;
    logic [3:0] v;

    initial begin
        sweep_exp = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_data  = '0;
        req_shamt = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        mon_en = 1'b1;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_data",  32'(rsp_data),  32'h00);
        chk("rst_id",    32'(rsp_id),    32'd0);
        chk("rst_ready", 32'(req_ready), 32'h0);

        // Single request then drain
        rst_n     = 1'b1;
        req_valid = 4'b0010;
        set_req(1, 8'h81, 3'd1);
        #1 chk("single_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b0000;
        chk("single_valid", 32'(rsp_valid), 32'd1);
        chk("single_data",  32'(rsp_data),  32'h02);
        chk("single_id",    32'(rsp_id),    32'd1);
        chk("single_ptr",   32'(dut.ptr_q), 32'd2);
        rsp_ready = 1'b1;
        tick();
        chk("single_drain", 32'(rsp_valid), 32'd0);

        // All four requesting from reset, consumer always ready
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        req_valid = 4'hF;
        for (int k = 0; k < 4; k++) set_req(k, 8'h01, 3'(k));
        for (int i = 0; i < 5; i++) begin
            #1 chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (i % 4)));
            tick();
            chk("rr_valid", 32'(rsp_valid), 32'd1);
            chk("rr_id",    32'(rsp_id),    32'(i % 4));
            chk("rr_data",  32'(rsp_data),  32'(8'h01 << (i % 4)));
        end

        // Backpressure for three cycles, then drain with a new grant
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_ready", 32'(req_ready), 32'h0);
            tick();
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data",  32'(rsp_data),  32'h01);
            chk("bp_id",    32'(rsp_id),    32'd0);
        end
        rsp_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(req_ready), 32'b0010);
        tick();
        chk("bp_b2b_valid", 32'(rsp_valid), 32'd1);
        chk("bp_b2b_id",    32'(rsp_id),    32'd1);
        chk("bp_b2b_data",  32'(rsp_data),  32'h02);
        req_valid = 4'b0000;
        tick();
        chk("bp_empty", 32'(rsp_valid), 32'd0);

        // Shift amount sweep through requester 2
        req_valid = 4'b0100;
        for (int s = 0; s < 8; s++) begin
            set_req(2, 8'hFF, 3'(s));
            tick();
            chk("sweep_data", 32'(rsp_data), 32'(sweep_exp[s]));
        end
        req_valid = 4'b0000;
        tick();

        // Reset while FULL with ptr at 3
        rsp_ready = 1'b0;
        set_req(2, 8'hFF, 3'd0);
        req_valid = 4'b0100;
        tick();
        chk("mid_full",  32'(rsp_valid), 32'd1);
        chk("mid_ptr",   32'(dut.ptr_q), 32'd3);
        rst_n     = 1'b0;
        req_valid = 4'b1010;
        #1 chk("mid_rst_ready", 32'(req_ready), 32'h0);
        tick();
        rst_n = 1'b1;
        chk("mid_valid", 32'(rsp_valid), 32'd0);
        chk("mid_data",  32'(rsp_data),  32'h00);
        chk("mid_id",    32'(rsp_id),    32'd0);
        chk("mid_ptr0",  32'(dut.ptr_q), 32'd0);
        #1 chk("mid_regrant", 32'(req_ready), 32'b0010);
        tick();
        chk("mid_regrant_id",   32'(rsp_id),   32'd1);
        chk("mid_regrant_data", 32'(rsp_data), 32'h02);
        rsp_ready = 1'b1;
        req_valid = 4'b0000;
        tick();

        // Fairness: req0 always valid, req2 toggles; ptr starts at 2
        mptr      = 2;
        wait0     = 0;
        max_wait0 = 0;
        for (int c = 0; c < 20; c++) begin
            v = {1'b0, c[0], 1'b0, 1'b1};
            req_valid = v;
            wexp = mptr;
            for (int j = 3; j >= 0; j--) if (v[(mptr + j) % 4]) wexp = (mptr + j) % 4;
            #1 chk("fair_ready", 32'(req_ready), 32'(4'b0001 << wexp));
            wobs = 0;
            for (int j = 0; j < 4; j++) if (req_ready[j]) wobs = j;
            if (wobs == 0) wait0 = 0;
            else begin
                wait0++;
                if (wait0 > max_wait0) max_wait0 = wait0;
            end
            mptr = (wexp + 1) % 4;
            tick();
        end
        chk("fair_wait0", 32'(max_wait0 < 4), 32'd1);

        req_valid = 4'b0000;
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_arbiter_8.md
SHIFT_ARBITER_8 -- requirements
Module: ShiftArbiter_8

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one 8-bit left shifter; fixed at 4 for this revision.
REQ-002 Port i_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 Port i_rst_n, input, 1, reset, synchronous, active-low.
REQ-004 Port i_req_valid, input, 4, per-requester request valid.
REQ-005 Port i_req_data, input, 32, per-requester operand; requester k occupies bits [8k+7:8k].
REQ-006 Port i_req_shamt, input, 12, per-requester shift amount; requester k occupies bits [3k+2:3k].
REQ-007 Port o_req_ready, input-accept strobe, output, 4, one-hot or zero grant; request k is transferred when i_req_valid[k] and o_req_ready[k] are both high.
REQ-008 Port o_rsp_valid, output, 1, result register holds a valid result.
REQ-009 Port o_rsp_data, output, 8, shifted result: operand shifted left by shamt, zero-filled, upper bits discarded.
REQ-010 Port o_rsp_id, output, 2, index of the requester that produced o_rsp_data.
REQ-011 Port i_rsp_ready, input, 1, consumer accepts the result when it and o_rsp_valid are both high.

Function
REQ-012 Block shall arbitrate round-robin: search starts at priority pointer ptr and proceeds ptr, ptr+1, ... modulo 4; the first requester with i_req_valid high wins.
REQ-013 Grant shall be issued, as o_req_ready[winner] high, only when the result register is EMPTY or is being drained in the same cycle (o_rsp_valid and i_rsp_ready).
REQ-014 o_req_ready shall be combinational from i_req_valid, ptr, state and i_rsp_ready; at most one bit shall be high, and no bit shall be high for a non-requesting index.
REQ-015 On a transfer, the result register shall load the shifted data and the winner id on the same edge; latency is 1 cycle from transfer to o_rsp_valid.
REQ-016 On a transfer, ptr shall become winner+1 modulo 4; with no transfer, ptr shall be unchanged.
REQ-017 Block shall have a 2-state FSM. EMPTY goes to FULL on a transfer. FULL goes to EMPTY on a drain without a transfer. FULL stays FULL on a drain with a simultaneous transfer (back-to-back) or when no drain occurs.
REQ-018 While FULL and i_rsp_ready is low, o_rsp_data and o_rsp_id shall hold stable and all o_req_ready bits shall be low.
REQ-019 Sustained throughput shall be one result per cycle when i_rsp_ready is held high.
REQ-020 A shamt of 0 shall pass the operand unchanged; a shamt of 7 shall yield {operand[0], 7'b0}.
REQ-021 Requesters shall hold data and shamt stable while valid is high and ready is low; the block shall not depend on valid being withdrawn.
REQ-022 Fairness: a continuously valid requester shall be granted within 4 transfers.

Reset
REQ-023 While i_rst_n is low at a clock edge, the block shall set state to EMPTY, o_rsp_valid to 0, o_rsp_data to 8'h00, o_rsp_id to 0 and ptr to 0.
REQ-024 During reset o_req_ready shall be all zero.
REQ-025 A reset asserted while FULL shall discard the pending result with no drain.
REQ-026 Grants shall resume on the first edge after i_rst_n returns high.

Structure
REQ-027 Shared package shall hold NUM_REQ, DATA_W=8, SHAMT_W=3, ID_W=2 and the state enum {EMPTY, FULL}.
REQ-028 The shift datapath shall be one instance of LeftShifter_8, fed by a 4:1 operand/shamt mux selected by the winner index.
REQ-029 The arbiter shall be priority logic on the request vector rotated by ptr, with no per-requester shifter.

Verification
REQ-030 Bench shall run single request then drain: req1 valid, data 8'h81, shamt 1 -> next cycle rsp_valid=1, data=8'h02, id=1; ptr=2.
REQ-031 Bench shall run all 4 valid with i_rsp_ready=1 from reset: grants 0,1,2,3,0 on consecutive cycles, one result per cycle.
REQ-032 Bench shall apply backpressure: FULL with i_rsp_ready=0 for 3 cycles -> o_rsp_data/id stable, o_req_ready=0; then ready=1 -> drain and simultaneous new grant, rsp_valid stays 1.
REQ-033 Bench shall sweep shamt boundaries: data 8'hFF with shamt 0..7 -> 8'hFF, FE, FC, F8, F0, E0, C0, 80.
REQ-034 Bench shall assert reset mid-operation: FULL with ptr=3, i_rst_n low one cycle -> rsp_valid=0, data=00, id=0, ptr=0; next grant goes to the lowest valid index.
REQ-035 Bench shall include a fairness check: req0 always valid, req2 toggling -> no requester waits more than 4 transfers; assertions enforce one-hot ready and stable output under stall.
